// File: rtl/cp0_exc_ctrl.sv
// ============================================================================
// Module      : cp0_exc_ctrl
// Description : Commit-point exception/interrupt arbiter. It strobes CP0 once
//               per event, then flushes the pipeline and redirects fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cm_valid,
    output logic        cm_ready,
    input  logic [31:0] cm_pc,
    input  logic        cm_bd,
    input  logic [31:0] cm_vaddr,
    input  logic        cm_adel_if,
    input  logic        cm_ri,
    input  logic        cm_ov,
    input  logic        cm_sys,
    input  logic        cm_bp,
    input  logic        cm_adel,
    input  logic        cm_ades,
    input  logic        cm_eret,
    input  logic        int_pending,
    input  logic [31:0] epc_in,
    output logic        cp0_exc_we,
    output logic [4:0]  cp0_exccode,
    output logic        cp0_bd,
    output logic [31:0] cp0_epc,
    output logic        cp0_badv_we,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_eret,
    output logic        flush,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        exc_we_q, exc_we_d;
    logic        badv_we_q, badv_we_d;
    logic        eret_q, eret_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        bd_q, bd_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic        w_exc;
    logic [4:0]  w_code;
    logic        w_badv;
    logic [31:0] w_badv_addr;

    // Fixed-priority pick of the winning exception; eret only wins when no exception is present.
    always_comb begin
        w_exc       = 1'b1;
        w_code      = 5'd0;
        w_badv      = 1'b0;
        w_badv_addr = 32'd0;
        if (int_pending) begin
            w_code = 5'd0;
        end else if (cm_adel_if) begin
            w_code      = 5'd4;
            w_badv      = 1'b1;
            w_badv_addr = cm_pc;
        end else if (cm_ri) begin
            w_code = 5'd10;
        end else if (cm_ov) begin
            w_code = 5'd12;
        end else if (cm_sys) begin
            w_code = 5'd8;
        end else if (cm_bp) begin
            w_code = 5'd9;
        end else if (cm_adel) begin
            w_code      = 5'd4;
            w_badv      = 1'b1;
            w_badv_addr = cm_vaddr;
        end else if (cm_ades) begin
            w_code      = 5'd5;
            w_badv      = 1'b1;
            w_badv_addr = cm_vaddr;
        end else begin
            w_exc = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        exc_we_d   = 1'b0;
        badv_we_d  = 1'b0;
        eret_d     = 1'b0;
        exccode_d  = exccode_q;
        bd_d       = bd_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        redir_pc_d = redir_pc_q;
        case (state_q)
            S_IDLE: begin
                if (cm_valid && (w_exc || cm_eret)) begin
                    state_d = S_FLUSH;
                    cnt_d   = 4'(FLUSH_CYCLES);
                    if (w_exc) begin
                        exc_we_d   = 1'b1;
                        exccode_d  = w_code;
                        bd_d       = cm_bd;
                        epc_d      = cm_bd ? (cm_pc - 32'd4) : cm_pc;
                        badv_we_d  = w_badv;
                        redir_pc_d = EXC_VECTOR;
                        if (w_badv) begin
                            badvaddr_d = w_badv_addr;
                        end
                    end else begin
                        eret_d     = 1'b1;
                        redir_pc_d = epc_in;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_REDIRECT: begin
                if (redir_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            exc_we_q   <= 1'b0;
            badv_we_q  <= 1'b0;
            eret_q     <= 1'b0;
            exccode_q  <= 5'd0;
            bd_q       <= 1'b0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            redir_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            exc_we_q   <= exc_we_d;
            badv_we_q  <= badv_we_d;
            eret_q     <= eret_d;
            exccode_q  <= exccode_d;
            bd_q       <= bd_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign cm_ready     = (state_q == S_IDLE);
    assign flush        = (state_q == S_FLUSH);
    assign redir_valid  = (state_q == S_REDIRECT);
    assign redir_pc     = redir_pc_q;
    assign cp0_exc_we   = exc_we_q;
    assign cp0_exccode  = exccode_q;
    assign cp0_bd       = bd_q;
    assign cp0_epc      = epc_q;
    assign cp0_badv_we  = badv_we_q;
    assign cp0_badvaddr = badvaddr_q;
    assign cp0_eret     = eret_q;

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
// ============================================================================
// Module      : tb_cp0_exc_ctrl
// Description : Directed self-checking bench for cp0_exc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_exc_ctrl;

    localparam logic [31:0] C_VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        cm_valid, cm_ready, cm_bd;
    logic [31:0] cm_pc, cm_vaddr, epc_in;
    logic        cm_adel_if, cm_ri, cm_ov, cm_sys, cm_bp, cm_adel, cm_ades, cm_eret;
    logic        int_pending;
    logic        cp0_exc_we, cp0_bd, cp0_badv_we, cp0_eret;
    logic [4:0]  cp0_exccode;
    logic [31:0] cp0_epc, cp0_badvaddr;
    logic        flush, redir_valid, redir_ready;
    logic [31:0] redir_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl #(.EXC_VECTOR(C_VEC), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_pc(cm_pc), .cm_bd(cm_bd),
        .cm_vaddr(cm_vaddr), .cm_adel_if(cm_adel_if), .cm_ri(cm_ri), .cm_ov(cm_ov),
        .cm_sys(cm_sys), .cm_bp(cm_bp), .cm_adel(cm_adel), .cm_ades(cm_ades),
        .cm_eret(cm_eret), .int_pending(int_pending), .epc_in(epc_in),
        .cp0_exc_we(cp0_exc_we), .cp0_exccode(cp0_exccode), .cp0_bd(cp0_bd),
        .cp0_epc(cp0_epc), .cp0_badv_we(cp0_badv_we), .cp0_badvaddr(cp0_badvaddr),
        .cp0_eret(cp0_eret), .flush(flush), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .redir_ready(redir_ready)
    );

    task automatic step();
        @(negedge clk);
    endtask

    // ev = {int, adel_if, ri, ov, sys, bp, adel, ades, eret}
    task automatic set_ev(input logic [8:0] ev);
        {int_pending, cm_adel_if, cm_ri, cm_ov, cm_sys, cm_bp, cm_adel, cm_ades, cm_eret} = ev;
    endtask

    // Presents one commit for a single edge; returns at the negedge of cycle T.
    task automatic commit(input logic [31:0] pc, input logic [31:0] va, input logic bd,
                          input logic [8:0] ev);
        cm_valid = 1'b1; cm_pc = pc; cm_vaddr = va; cm_bd = bd;
        set_ev(ev);
        step();
        cm_valid = 1'b0;
        set_ev(9'd0);
    endtask

    task automatic finish_seq(input logic [31:0] exp_pc, input string nm);
        int fl = 0;
        while (flush === 1'b1 && fl < 40) begin
            fl++;
            step();
            total++;
            if (cp0_exc_we !== 1'b0 || cp0_eret !== 1'b0 || cp0_badv_we !== 1'b0) begin
                bad++;
                $display("FAIL %s pulse_width: exc_we=%b eret=%b badv_we=%b required 0", nm,
                         cp0_exc_we, cp0_eret, cp0_badv_we);
            end
        end
        total++;
        if (fl !== 2) begin
            bad++;
            $display("FAIL %s flush_len: got %0d required 2", nm, fl);
        end
        total++;
        if (redir_valid !== 1'b1 || redir_pc !== exp_pc) begin
            bad++;
            $display("FAIL %s redirect: valid=%b pc=%h required 1/%h", nm, redir_valid, redir_pc, exp_pc);
        end
        step();
        total++;
        if (cm_ready !== 1'b1 || redir_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s back_idle: cm_ready=%b redir_valid=%b required 1/0", nm, cm_ready, redir_valid);
        end
    endtask

    task automatic test_reset();
        total++;
        if (cm_ready !== 1'b1 || cp0_exc_we !== 1'b0 || cp0_eret !== 1'b0 || flush !== 1'b0 ||
            redir_valid !== 1'b0 || redir_pc !== 32'd0 || cp0_exccode !== 5'd0 || cp0_epc !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: ready=%b exc_we=%b eret=%b flush=%b rv=%b rpc=%h code=%0d epc=%h",
                     cm_ready, cp0_exc_we, cp0_eret, flush, redir_valid, redir_pc, cp0_exccode, cp0_epc);
        end
    endtask

    task automatic test_overflow();
        total++;
        if (cm_ready !== 1'b1) begin
            bad++;
            $display("FAIL ov_ready_before: got %b required 1", cm_ready);
        end
        commit(32'h8000_1000, 32'h0, 1'b0, 9'b000100000);
        total++;
        if (cp0_exc_we !== 1'b1 || cp0_exccode !== 5'd12 || cp0_epc !== 32'h8000_1000 ||
            cp0_bd !== 1'b0 || cp0_badv_we !== 1'b0 || cp0_eret !== 1'b0 || flush !== 1'b1 ||
            cm_ready !== 1'b0 || redir_valid !== 1'b0) begin
            bad++;
            $display("FAIL ov_accept: we=%b code=%0d epc=%h bd=%b bwe=%b eret=%b flush=%b rdy=%b rv=%b required 1/12/80001000/0/0/0/1/0/0",
                     cp0_exc_we, cp0_exccode, cp0_epc, cp0_bd, cp0_badv_we, cp0_eret, flush, cm_ready, redir_valid);
        end
        finish_seq(C_VEC, "ov");
    endtask

    task automatic test_delay_slot();
        commit(32'h8000_0008, 32'h0, 1'b1, 9'b000010000);
        total++;
        if (cp0_exc_we !== 1'b1 || cp0_exccode !== 5'd8 || cp0_bd !== 1'b1 || cp0_epc !== 32'h8000_0004) begin
            bad++;
            $display("FAIL ds_sys: we=%b code=%0d bd=%b epc=%h required 1/8/1/80000004",
                     cp0_exc_we, cp0_exccode, cp0_bd, cp0_epc);
        end
        finish_seq(C_VEC, "ds");
        commit(32'h0000_0000, 32'h0, 1'b1, 9'b000001000);
        total++;
        if (cp0_exccode !== 5'd9 || cp0_epc !== 32'hFFFF_FFFC || cp0_bd !== 1'b1) begin
            bad++;
            $display("FAIL ds_wrap: code=%0d epc=%h bd=%b required 9/fffffffc/1", cp0_exccode, cp0_epc, cp0_bd);
        end
        finish_seq(C_VEC, "ds_wrap");
    endtask

    task automatic test_priority();
        commit(32'h8000_0020, 32'h0000_0003, 1'b0, 9'b101000100);
        total++;
        if (cp0_exc_we !== 1'b1 || cp0_exccode !== 5'd0 || cp0_badv_we !== 1'b0) begin
            bad++;
            $display("FAIL prio_int: we=%b code=%0d bwe=%b required 1/0/0", cp0_exc_we, cp0_exccode, cp0_badv_we);
        end
        finish_seq(C_VEC, "prio_int");
        commit(32'h8000_0002, 32'h0000_1234, 1'b0, 9'b010000100);
        total++;
        if (cp0_exccode !== 5'd4 || cp0_badv_we !== 1'b1 || cp0_badvaddr !== 32'h8000_0002) begin
            bad++;
            $display("FAIL prio_adel_if: code=%0d bwe=%b badv=%h required 4/1/80000002",
                     cp0_exccode, cp0_badv_we, cp0_badvaddr);
        end
        finish_seq(C_VEC, "prio_adel_if");
        commit(32'h8000_0040, 32'h0000_0007, 1'b0, 9'b000000010);
        total++;
        if (cp0_exccode !== 5'd5 || cp0_badv_we !== 1'b1 || cp0_badvaddr !== 32'h0000_0007) begin
            bad++;
            $display("FAIL ades: code=%0d bwe=%b badv=%h required 5/1/00000007",
                     cp0_exccode, cp0_badv_we, cp0_badvaddr);
        end
        finish_seq(C_VEC, "ades");
        commit(32'h8000_0044, 32'h0000_0009, 1'b0, 9'b000100100);
        total++;
        if (cp0_exccode !== 5'd12 || cp0_badv_we !== 1'b0) begin
            bad++;
            $display("FAIL ov_over_adel: code=%0d bwe=%b required 12/0", cp0_exccode, cp0_badv_we);
        end
        finish_seq(C_VEC, "ov_over_adel");
    endtask

    task automatic test_eret();
        epc_in = 32'h8000_0100;
        commit(32'h8000_0050, 32'h0, 1'b0, 9'b000000001);
        epc_in = 32'h1111_1111;
        total++;
        if (cp0_eret !== 1'b1 || cp0_exc_we !== 1'b0 || flush !== 1'b1) begin
            bad++;
            $display("FAIL eret_accept: eret=%b exc_we=%b flush=%b required 1/0/1", cp0_eret, cp0_exc_we, flush);
        end
        finish_seq(32'h8000_0100, "eret");
        epc_in = 32'h8000_0100;
        commit(32'h8000_0060, 32'h0, 1'b0, 9'b000001001);
        total++;
        if (cp0_exc_we !== 1'b1 || cp0_exccode !== 5'd9 || cp0_eret !== 1'b0) begin
            bad++;
            $display("FAIL eret_bp: we=%b code=%0d eret=%b required 1/9/0", cp0_exc_we, cp0_exccode, cp0_eret);
        end
        finish_seq(C_VEC, "eret_bp");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        redir_ready = 1'b0;
        commit(32'h8000_0200, 32'h0, 1'b0, 9'b000100000);
        while (redir_valid !== 1'b1 && n < 20) begin
            n++;
            step();
        end
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL hs_latency: cycles=%0d required 2", n);
        end
        cm_valid = 1'b1; cm_ov = 1'b1; cm_pc = 32'h8000_0300;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (redir_valid !== 1'b1 || redir_pc !== C_VEC || cm_ready !== 1'b0 ||
                cp0_exc_we !== 1'b0 || flush !== 1'b0) begin
                bad++;
                $display("FAIL hs_hold[%0d]: rv=%b rpc=%h rdy=%b we=%b flush=%b required 1/%h/0/0/0",
                         i, redir_valid, redir_pc, cm_ready, cp0_exc_we, flush, C_VEC);
            end
        end
        cm_valid = 1'b0; cm_ov = 1'b0; redir_ready = 1'b1;
        step();
        total++;
        if (cm_ready !== 1'b1 || redir_valid !== 1'b0 || cp0_exc_we !== 1'b0) begin
            bad++;
            $display("FAIL hs_release: rdy=%b rv=%b we=%b required 1/0/0", cm_ready, redir_valid, cp0_exc_we);
        end
    endtask

    task automatic test_reset_mid();
        commit(32'h8000_0400, 32'h0, 1'b0, 9'b000100000);
        rst = 1'b0;
        #1;
        total++;
        if (flush !== 1'b0 || cp0_exc_we !== 1'b0 || redir_valid !== 1'b0 || cp0_eret !== 1'b0 ||
            cp0_exccode !== 5'd0 || cp0_epc !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid: flush=%b we=%b rv=%b eret=%b code=%0d epc=%h required all 0",
                     flush, cp0_exc_we, redir_valid, cp0_eret, cp0_exccode, cp0_epc);
        end
        step();
        rst = 1'b1;
        int_pending = 1'b1;
        step();
        step();
        total++;
        if (cm_ready !== 1'b1 || cp0_exc_we !== 1'b0 || flush !== 1'b0) begin
            bad++;
            $display("FAIL int_no_valid: rdy=%b we=%b flush=%b required 1/0/0", cm_ready, cp0_exc_we, flush);
        end
        int_pending = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cm_valid = 1'b0; cm_pc = 32'd0; cm_bd = 1'b0; cm_vaddr = 32'd0;
        epc_in = 32'd0; redir_ready = 1'b1;
        set_ev(9'd0);
        step();
        test_reset();
        step();
        rst = 1'b1;
        step();
        test_overflow();
        test_delay_slot();
        test_priority();
        test_eret();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
